// File: rtl/ahb_console_writer.sv
// AHB-Lite master draining a byte FIFO into single NONSEQ word writes to TARGET_ADDR.
// Latency: a push at edge N is presented as NONSEQ after N and is accepted at N+1.
// Backpressure: HREADY=0 freezes both phases; in_ready drops at full. HRESP handling needs AHB_CONSOLE_WRITER_ERR_EN.
module ahb_console_writer #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [31:0] TARGET_ADDR = 32'h5000_0000
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic [31:0]                   HADDR,
  output logic [1:0]                    HTRANS,
  output logic                          HWRITE,
  output logic [2:0]                    HSIZE,
  output logic [2:0]                    HBURST,
  output logic [3:0]                    HPROT,
  output logic [31:0]                   HWDATA,
  input  logic                          HREADY,
  input  logic                          HRESP,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err,
  input  logic                          err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          dp_valid;
  logic [7:0]    dp_data;
  logic          idle_force;
  logic          nonseq;
  logic          push;
  logic          pop;

  assign in_ready = (fifo_level < LW'(FIFO_DEPTH));
  assign push     = in_valid & in_ready;
  assign nonseq   = (fifo_level != '0) & ~idle_force;
  assign pop      = HREADY & nonseq;

  assign HADDR  = TARGET_ADDR;
  assign HTRANS = nonseq ? 2'b10 : 2'b00;
  assign HWRITE = 1'b1;
  assign HSIZE  = 3'b010;
  assign HBURST = 3'b000;
  assign HPROT  = 4'b0011;
  assign HWDATA = {24'h0, dp_data};
  assign busy   = (fifo_level != '0) | dp_valid;

  // Storage has no reset; occupancy and pointers define what is valid.
  always_ff @(posedge HCLK) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_valid <= 1'b0;
      dp_data  <= 8'h00;
    end else if (HREADY) begin
      dp_valid <= nonseq;
      if (nonseq) dp_data <= mem[rd_ptr];
    end
  end

`ifdef AHB_CONSOLE_WRITER_ERR_EN
  logic err_hold;
  logic err_first;
  logic err_q;

  // First cycle of a two-cycle ERROR response; the address phase is cancelled for it and the next.
  assign err_first  = HRESP & ~HREADY & dp_valid & ~err_hold;
  assign idle_force = err_first | err_hold;
  assign err        = err_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      err_hold <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_hold <= err_first;
      if (err_first)    err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
    end
  end
`else
  logic unused_err;
  assign unused_err = &{1'b0, HRESP, err_clr};
  assign idle_force = 1'b0;
  assign err        = 1'b0;
`endif

endmodule
